// File: rtl/accelerator_fnn_load_sequencer_pkg.sv
// Shared definitions for the FNN load sequencer.
//   - FSM state encodings (IDLE .. DONE)
//   - default data/size width and an all-zero constant used for size tests
package accelerator_fnn_sequencer_pkg;

  localparam int unsigned DATA_SIZE_DEF = 64;

  localparam logic [DATA_SIZE_DEF-1:0] ZERO = '0;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_X = 3'd1;
  localparam logic [2:0] LOAD_W = 3'd2;
  localparam logic [2:0] LOAD_B = 3'd3;
  localparam logic [2:0] RUN    = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

endpackage

// File: rtl/accelerator_fnn_load_sequencer_if.sv
// Bus bundle between the stream fabric / FNN controller and the sequencer.
// Suffixes are from the sequencer's point of view.
//   slave  : sequencer side (drives *_o, samples *_i)
//   master : environment side (drives *_i, samples *_o)
// Signals: start/ready command handshake, latched sizes, operand stream
// (data_in/valid/ready), forwarded h stream (data_out/valid) and the
// FNN controller strobes (x/w/b load, start, h out, ready).
interface accelerator_fnn_load_sequencer_if #(
  parameter int unsigned DATA_SIZE = 64
);
  logic                 start_i;
  logic                 ready_o;
  logic [DATA_SIZE-1:0] size_x_i;
  logic [DATA_SIZE-1:0] size_l_i;
  logic [DATA_SIZE-1:0] data_in_i;
  logic                 data_in_valid_i;
  logic                 data_in_ready_o;
  logic [DATA_SIZE-1:0] data_out_o;
  logic                 data_out_valid_o;
  logic                 fnn_start_o;
  logic                 fnn_ready_i;
  logic                 fnn_x_in_enable_o;
  logic [DATA_SIZE-1:0] fnn_x_in_o;
  logic                 fnn_w_in_l_enable_o;
  logic                 fnn_w_in_x_enable_o;
  logic [DATA_SIZE-1:0] fnn_w_in_o;
  logic                 fnn_b_in_enable_o;
  logic [DATA_SIZE-1:0] fnn_b_in_o;
  logic                 fnn_h_out_enable_i;
  logic [DATA_SIZE-1:0] fnn_h_out_i;

  modport slave (
    input  start_i, size_x_i, size_l_i, data_in_i, data_in_valid_i,
           fnn_ready_i, fnn_h_out_enable_i, fnn_h_out_i,
    output ready_o, data_in_ready_o, data_out_o, data_out_valid_o,
           fnn_start_o, fnn_x_in_enable_o, fnn_x_in_o, fnn_w_in_l_enable_o,
           fnn_w_in_x_enable_o, fnn_w_in_o, fnn_b_in_enable_o, fnn_b_in_o
  );

  modport master (
    output start_i, size_x_i, size_l_i, data_in_i, data_in_valid_i,
           fnn_ready_i, fnn_h_out_enable_i, fnn_h_out_i,
    input  ready_o, data_in_ready_o, data_out_o, data_out_valid_o,
           fnn_start_o, fnn_x_in_enable_o, fnn_x_in_o, fnn_w_in_l_enable_o,
           fnn_w_in_x_enable_o, fnn_w_in_o, fnn_b_in_enable_o, fnn_b_in_o
  );
endinterface

// File: rtl/accelerator_fnn_load_sequencer_index_counter.sv
// 2-D (i,j) index counter. j runs 0..lim_j-1; on wrap it clears and i
// advances 0..lim_i-1, wrapping to 0 after the last element.
// With lim_i = 1 it behaves as a plain 1-D counter.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   clr_i             synchronous clear of both indices (priority)
//   step_i            advance by one element
//   lim_j_i, lim_i_i  extents (must be non-zero while stepping)
//   j_o               current column index
//   last_j_o/last_i_o current element is the last column / last row
module accelerator_fnn_index_counter #(
  parameter int unsigned W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         step_i,
  input  logic [W-1:0] lim_j_i,
  input  logic [W-1:0] lim_i_i,
  output logic [W-1:0] j_o,
  output logic         last_j_o,
  output logic         last_i_o
);
  logic [W-1:0] j_q, j_d, i_q, i_d;

  assign j_o      = j_q;
  assign last_j_o = (j_q == lim_j_i - W'(1));
  assign last_i_o = (i_q == lim_i_i - W'(1));

  always_comb begin
    j_d = j_q;
    i_d = i_q;
    if (clr_i) begin
      j_d = '0;
      i_d = '0;
    end else if (step_i) begin
      if (last_j_o) begin
        j_d = '0;
        i_d = last_i_o ? '0 : i_q + W'(1);
      end else begin
        j_d = j_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      j_q <= '0;
      i_q <= '0;
    end else begin
      j_q <= j_d;
      i_q <= i_d;
    end
  end
endmodule

// File: rtl/accelerator_fnn_load_sequencer.sv
// Sequences one FNN pass: streams x, W (row-major), b from a single operand
// stream into the controller, pulses fnn_start, forwards up to SIZE_L h words
// and finishes with a one-cycle ready pulse.
// Ports:
//   clk_i, rst_i  clock, async active-high reset
//   bus           slave modport of accelerator_fnn_load_sequencer_if
//                 (command, operand stream, result stream, controller strobes)
module accelerator_fnn_load_sequencer
  import accelerator_fnn_sequencer_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  accelerator_fnn_load_sequencer_if.slave       bus
);
  logic [2:0]           state_q, state_d;
  logic [DATA_SIZE-1:0] size_x_q, size_l_q, h_cnt_q;
  logic [DATA_SIZE-1:0] lim_j, lim_i, j_idx;
  logic                 in_load, beat, last_j, last_i, phase_end, h_take, size_zero;

  logic                 x_en_q, wl_en_q, wx_en_q, b_en_q, b_last_q;
  logic                 fnn_start_q, dout_vld_q, ready_q;
  logic [DATA_SIZE-1:0] x_q, w_q, b_q, dout_q;

  assign in_load   = (state_q == LOAD_X) || (state_q == LOAD_W) || (state_q == LOAD_B);
  assign beat      = bus.data_in_valid_i & in_load;
  assign phase_end = beat & last_j & last_i;
  assign h_take    = (state_q == RUN) & bus.fnn_h_out_enable_i & (h_cnt_q < size_l_q);
  assign size_zero = (bus.size_x_i == DATA_SIZE'(ZERO)) || (bus.size_l_i == DATA_SIZE'(ZERO));

  // x and b are 1-D walks (single row); W walks SIZE_L rows of SIZE_X.
  always_comb begin
    lim_j = (state_q == LOAD_B) ? size_l_q : size_x_q;
    lim_i = (state_q == LOAD_W) ? size_l_q : DATA_SIZE'(1);
  end

  accelerator_fnn_index_counter #(.W(DATA_SIZE)) u_idx (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (!in_load),
    .step_i   (beat),
    .lim_j_i  (lim_j),
    .lim_i_i  (lim_i),
    .j_o      (j_idx),
    .last_j_o (last_j),
    .last_i_o (last_i)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (bus.start_i) state_d = size_zero ? DONE : LOAD_X;
      LOAD_X: if (phase_end) state_d = LOAD_W;
      LOAD_W: if (phase_end) state_d = LOAD_B;
      LOAD_B: if (phase_end) state_d = RUN;
      RUN:    if (bus.fnn_ready_i) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      size_x_q    <= '0;
      size_l_q    <= '0;
      h_cnt_q     <= '0;
      x_en_q      <= 1'b0;
      wl_en_q     <= 1'b0;
      wx_en_q     <= 1'b0;
      b_en_q      <= 1'b0;
      b_last_q    <= 1'b0;
      fnn_start_q <= 1'b0;
      dout_vld_q  <= 1'b0;
      ready_q     <= 1'b0;
      x_q         <= '0;
      w_q         <= '0;
      b_q         <= '0;
      dout_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.start_i) begin
        size_x_q <= bus.size_x_i;
        size_l_q <= bus.size_l_i;
      end

      x_en_q  <= beat && (state_q == LOAD_X);
      wx_en_q <= beat && (state_q == LOAD_W);
      wl_en_q <= beat && (state_q == LOAD_W) && (j_idx == '0);
      b_en_q  <= beat && (state_q == LOAD_B);
      if (beat && state_q == LOAD_X) x_q <= bus.data_in_i;
      if (beat && state_q == LOAD_W) w_q <= bus.data_in_i;
      if (beat && state_q == LOAD_B) b_q <= bus.data_in_i;

      // b_last_q lines up with the last b enable, so start lands one later.
      b_last_q    <= phase_end && (state_q == LOAD_B);
      fnn_start_q <= b_last_q;

      dout_vld_q <= h_take;
      if (h_take) dout_q <= bus.fnn_h_out_i;
      if (state_q == IDLE)  h_cnt_q <= '0;
      else if (h_take)      h_cnt_q <= h_cnt_q + DATA_SIZE'(1);

      ready_q <= (state_q == DONE);
    end
  end

  assign bus.data_in_ready_o     = in_load;
  assign bus.ready_o             = ready_q;
  assign bus.data_out_o          = dout_q;
  assign bus.data_out_valid_o    = dout_vld_q;
  assign bus.fnn_start_o         = fnn_start_q;
  assign bus.fnn_x_in_enable_o   = x_en_q;
  assign bus.fnn_x_in_o          = x_q;
  assign bus.fnn_w_in_l_enable_o = wl_en_q;
  assign bus.fnn_w_in_x_enable_o = wx_en_q;
  assign bus.fnn_w_in_o          = w_q;
  assign bus.fnn_b_in_enable_o   = b_en_q;
  assign bus.fnn_b_in_o          = b_q;
endmodule

// File: tb/tb_accelerator_fnn_load_sequencer.sv
// Bench for accelerator_fnn_load_sequencer: table of pass descriptors with
// hand-written expectations, hand sequences for reset, and randomized passes
// checked against a stream-order model of a pass.
module tb_accelerator_fnn_load_sequencer;
  import accelerator_fnn_sequencer_pkg::*;

  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  accelerator_fnn_load_sequencer_if #(.DATA_SIZE(DW)) bus();
  accelerator_fnn_load_sequencer #(.DATA_SIZE(DW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct packed { logic [63:0] d; int c; logic l; } ev_t;
  typedef struct { int x; int l; int vmode; int nh; bit spam; int exp_fwd; bit exp_fs; } vec_t;

  int n_chk = 0, n_pass = 0, cyc = 0;
  ev_t xq[$], wq[$], bq[$], oq[$];
  int en_cyc[$], fs_cyc[$], rdy_cyc[$];
  int dir_cnt, bad_l;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic sample();
    ev_t e;
    e.c = cyc;
    e.l = 1'b0;
    if (bus.fnn_x_in_enable_o) begin e.d = bus.fnn_x_in_o; xq.push_back(e); en_cyc.push_back(cyc); end
    if (bus.fnn_w_in_x_enable_o) begin
      e.d = bus.fnn_w_in_o; e.l = bus.fnn_w_in_l_enable_o; wq.push_back(e); en_cyc.push_back(cyc);
    end
    if (bus.fnn_w_in_l_enable_o && !bus.fnn_w_in_x_enable_o) bad_l++;
    if (bus.fnn_b_in_enable_o) begin e.d = bus.fnn_b_in_o; e.l = 1'b0; bq.push_back(e); en_cyc.push_back(cyc); end
    if (bus.fnn_start_o) fs_cyc.push_back(cyc);
    if (bus.data_out_valid_o) begin e.d = bus.data_out_o; oq.push_back(e); end
    if (bus.ready_o) rdy_cyc.push_back(cyc);
    if (bus.data_in_ready_o) dir_cnt++;
  endtask

  // Observe at the falling edge, then the caller drives inputs for the next rise.
  task automatic step();
    @(negedge clk);
    cyc++;
    sample();
  endtask

  task automatic clear_mon();
    xq.delete(); wq.delete(); bq.delete(); oq.delete();
    en_cyc.delete(); fs_cyc.delete(); rdy_cyc.delete();
    dir_cnt = 0; bad_l = 0;
  endtask

  task automatic run_pass(input vec_t v, input bit rnd_h);
    logic [63:0] strm[$];
    logic [63:0] hv[$];
    int acc[$], hc[$];
    int n, k, t0, guard, fr_c, nw, bad_t;
    clear_mon();
    // Model: the operand stream is x, then W row-major, then b.
    n  = (v.x == 0 || v.l == 0) ? 0 : v.x + v.x * v.l + v.l;
    nw = v.x * v.l;
    for (int q = 0; q < n; q++) strm.push_back({$urandom, $urandom});
    for (int q = 0; q < v.nh; q++) hv.push_back(rnd_h ? {$urandom, $urandom} : 64'hA + 64'(q));

    bus.size_x_i = 64'(v.x);
    bus.size_l_i = 64'(v.l);
    bus.start_i  = 1'b1;
    t0 = cyc;
    step();
    bus.start_i  = v.spam;
    bus.size_x_i = 64'($urandom_range(1, 9));
    bus.size_l_i = 64'($urandom_range(1, 9));

    k = 0; guard = 0;
    while (k < n && guard < 2000) begin
      case (v.vmode)
        0:       bus.data_in_valid_i = 1'b1;
        1:       bus.data_in_valid_i = (guard % 2) == 0;
        default: bus.data_in_valid_i = 1'($urandom % 2);
      endcase
      bus.data_in_i = strm[k];
      if (bus.data_in_valid_i && bus.data_in_ready_o) begin acc.push_back(cyc); k++; end
      step();
      guard++;
    end
    bus.data_in_valid_i = 1'b0;
    bus.start_i = 1'b0;
    chk("beats_accepted", 64'(k), 64'(n));

    guard = 0;
    while (fs_cyc.size() == 0 && rdy_cyc.size() == 0 && guard < 50) begin step(); guard++; end
    if (v.exp_fs) chk("ready_low_in_run", 64'(bus.data_in_ready_o), 64'd0);

    for (int q = 0; q < v.nh; q++) begin
      bus.fnn_h_out_enable_i = 1'b1;
      bus.fnn_h_out_i = hv[q];
      hc.push_back(cyc);
      step();
    end
    bus.fnn_h_out_enable_i = 1'b0;
    bus.fnn_ready_i = 1'b1;
    fr_c = cyc;
    step();
    bus.fnn_ready_i = 1'b0;
    repeat (4) step();

    // Operand enables: one per accepted beat, one cycle after it.
    chk("enable_count", 64'(en_cyc.size()), 64'(acc.size()));
    bad_t = 0;
    for (int q = 0; q < en_cyc.size() && q < acc.size(); q++)
      if (en_cyc[q] != acc[q] + 1) bad_t++;
    chk("enable_latency", 64'(bad_t), 64'd0);
    chk("l_without_x", 64'(bad_l), 64'd0);

    chk("x_count", 64'(xq.size()), 64'(n == 0 ? 0 : v.x));
    for (int q = 0; q < xq.size() && q < n; q++) chk("x_word", xq[q].d, strm[q]);
    chk("w_count", 64'(wq.size()), 64'(n == 0 ? 0 : nw));
    for (int q = 0; q < wq.size() && q < nw && n > 0; q++) begin
      chk("w_word", wq[q].d, strm[v.x + q]);
      chk("w_row_start", 64'(wq[q].l), 64'((q % v.x) == 0));
    end
    chk("b_count", 64'(bq.size()), 64'(n == 0 ? 0 : v.l));
    for (int q = 0; q < bq.size() && q < v.l && n > 0; q++) chk("b_word", bq[q].d, strm[v.x + nw + q]);

    chk("fnn_start_count", 64'(fs_cyc.size()), 64'(v.exp_fs));
    if (v.exp_fs && fs_cyc.size() > 0 && bq.size() > 0)
      chk("fnn_start_timing", 64'(fs_cyc[0]), 64'(bq[bq.size()-1].c + 1));
    if (!v.exp_fs) chk("zero_pass_no_ready_in", 64'(dir_cnt), 64'd0);

    chk("fwd_count", 64'(oq.size()), 64'(v.exp_fwd));
    for (int q = 0; q < oq.size() && q < v.exp_fwd; q++) begin
      chk("fwd_word", oq[q].d, hv[q]);
      chk("fwd_latency", 64'(oq[q].c), 64'(hc[q] + 1));
    end

    chk("ready_count", 64'(rdy_cyc.size()), 64'd1);
    if (rdy_cyc.size() > 0)
      chk("ready_timing", 64'(rdy_cyc[0]), 64'(v.exp_fs ? fr_c + 2 : t0 + 2));
    chk("idle_after_pass", 64'(dut.state_q), 64'(IDLE));
  endtask

  function automatic logic any_out();
    return |{bus.ready_o, bus.data_in_ready_o, bus.data_out_o, bus.data_out_valid_o,
             bus.fnn_start_o, bus.fnn_x_in_enable_o, bus.fnn_x_in_o, bus.fnn_w_in_l_enable_o,
             bus.fnn_w_in_x_enable_o, bus.fnn_w_in_o, bus.fnn_b_in_enable_o, bus.fnn_b_in_o};
  endfunction

  vec_t tbl[8];
  vec_t rv;

  initial begin
    // x, l, vmode(0 cont / 1 toggle / 2 random), nh, spam start, exp fwd, exp fnn_start
    tbl[0] = '{2, 2, 0, 2, 1'b0, 2, 1'b1};
    tbl[1] = '{2, 2, 1, 2, 1'b0, 2, 1'b1};
    tbl[2] = '{2, 2, 0, 3, 1'b0, 2, 1'b1};
    tbl[3] = '{2, 2, 0, 0, 1'b0, 0, 1'b1};
    tbl[4] = '{2, 0, 0, 2, 1'b0, 0, 1'b0};
    tbl[5] = '{0, 3, 0, 0, 1'b0, 0, 1'b0};
    tbl[6] = '{3, 2, 2, 1, 1'b1, 1, 1'b1};
    tbl[7] = '{1, 1, 0, 1, 1'b0, 1, 1'b1};

    bus.start_i = 1'b0; bus.size_x_i = '0; bus.size_l_i = '0;
    bus.data_in_i = '0; bus.data_in_valid_i = 1'b0;
    bus.fnn_ready_i = 1'b0; bus.fnn_h_out_enable_i = 1'b0; bus.fnn_h_out_i = '0;
    clear_mon();

    step(); step();
    chk("reset_outputs", 64'(any_out()), 64'd0);
    chk("reset_state", 64'(dut.state_q), 64'(IDLE));
    rst = 1'b0;
    step();

    for (int r = 0; r < 8; r++) run_pass(tbl[r], 1'b0);

    // Reset asserted mid-LOAD_W, between clock edges.
    bus.size_x_i = 64'd2; bus.size_l_i = 64'd2; bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    bus.data_in_valid_i = 1'b1;
    for (int q = 0; q < 4; q++) begin bus.data_in_i = 64'h100 + 64'(q); step(); end
    chk("in_load_w", 64'(dut.state_q), 64'(LOAD_W));
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", 64'(any_out()), 64'd0);
    chk("async_reset_state", 64'(dut.state_q), 64'(IDLE));
    bus.data_in_valid_i = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    run_pass(tbl[7], 1'b0);

    for (int r = 0; r < 10; r++) begin
      rv.x = $urandom_range(0, 4);
      rv.l = $urandom_range(0, 4);
      rv.vmode = 2;
      rv.nh = $urandom_range(0, 5);
      rv.exp_fs = (rv.x != 0) && (rv.l != 0);
      rv.spam = rv.exp_fs ? 1'($urandom % 2) : 1'b0;
      rv.exp_fwd = !rv.exp_fs ? 0 : (rv.nh < rv.l ? rv.nh : rv.l);
      run_pass(rv, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
